rr_priority_arbiter: RTL and testbench

RR_PRIORITY_ARBITER -- requirements
Module: rr_priority_arbiter

---
 rtl/rr_priority_arbiter_if.sv | 23 ++
 rtl/rr_priority_arbiter.sv | 87 ++++++++
 tb/tb_rr_priority_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between a set of requesters plus a grant consumer and the arbiter.
// The master side drives requests and acks; the slave side (arbiter) offers registered grants.
interface rr_priority_arbiter_if #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
);
  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic               grant_ack;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;

  modport master (
    output enable, req, grant_ack,
    input  grant_valid, grant_idx, grant_onehot
  );

  modport slave (
    input  enable, req, grant_ack,
    output grant_valid, grant_idx, grant_onehot
  );
endinterface

// File: rtl/rr_priority_arbiter.sv
// Registered request arbiter: rotating priority (ROUND_ROBIN=1) or fixed lowest-index priority.
// A grant is held stable until acked; on the ack cycle a new winner is chosen with no idle gap.
module rr_priority_arbiter #(
  parameter int NUM_REQ     = 16,
  parameter int IDX_W       = 4,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_priority_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grantIdx_q, grantIdx_d;
  logic [NUM_REQ-1:0] grantOnehot_q, grantOnehot_d;

  logic               arbPoint;
  logic               found;
  logic [IDX_W-1:0]   scanBase;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grantIdx_q    <= '0;
      grantOnehot_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grantIdx_q    <= grantIdx_d;
      grantOnehot_q <= grantOnehot_d;
    end
  end

  // The scan uses the already-advanced pointer so an ack can hand over in the same cycle.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grantIdx_d    = grantIdx_q;
    grantOnehot_d = grantOnehot_q;
    found         = 1'b0;
    winner        = '0;
    cand          = '0;

    arbPoint = (state_q == IDLE) || bus.grant_ack;

    if ((state_q == HOLD) && bus.grant_ack) begin
      ptr_d = grantIdx_q + IDX_W'(1);
    end

    scanBase = (ROUND_ROBIN != 0) ? ptr_d : '0;

    for (int k = 0; k < NUM_REQ; k++) begin
      cand = scanBase + IDX_W'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    if (arbPoint) begin
      if (bus.enable && found) begin
        state_d               = HOLD;
        grantIdx_d            = winner;
        grantOnehot_d         = '0;
        grantOnehot_d[winner] = 1'b1;
      end else begin
        state_d       = IDLE;
        grantIdx_d    = '0;
        grantOnehot_d = '0;
      end
    end
  end

  assign bus.grant_valid  = (state_q == HOLD);
  assign bus.grant_idx    = grantIdx_q;
  assign bus.grant_onehot = grantOnehot_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter: 16-way round-robin, 16-way fixed and 4-way round-robin instances.
// Expected grants are hand-derived and checked with immediate assertions.
module tb_rr_priority_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_priority_arbiter_if #(.NUM_REQ(16), .IDX_W(4)) b16 ();
  rr_priority_arbiter_if #(.NUM_REQ(16), .IDX_W(4)) bF ();
  rr_priority_arbiter_if #(.NUM_REQ(4),  .IDX_W(2)) b4 ();

  rr_priority_arbiter #(.NUM_REQ(16), .IDX_W(4), .ROUND_ROBIN(1)) dutRr16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  rr_priority_arbiter #(.NUM_REQ(16), .IDX_W(4), .ROUND_ROBIN(0)) dutFixed16 (
    .clk (clk),
    .rst (rst),
    .bus (bF)
  );

  rr_priority_arbiter #(.NUM_REQ(4), .IDX_W(2), .ROUND_ROBIN(1)) dutRr4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the rising edge, inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkGrant(input string tag, input logic valid, input logic [63:0] idx,
                            input logic [63:0] onehot, input logic expValid, input int expIdx);
    logic [63:0] expOnehot;
    expOnehot = expValid ? (64'd1 << expIdx) : 64'd0;
    checkOutput({tag, "/valid"},  {63'd0, valid}, {63'd0, expValid});
    checkOutput({tag, "/idx"},    idx, expValid ? 64'(expIdx) : 64'd0);
    checkOutput({tag, "/onehot"}, onehot, expOnehot);
  endtask

  task automatic checkRr16(input string tag, input logic expValid, input int expIdx);
    checkGrant(tag, b16.grant_valid, 64'(b16.grant_idx), 64'(b16.grant_onehot), expValid, expIdx);
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] r, input logic ack);
    b16.enable    = en;
    b16.req       = r;
    b16.grant_ack = ack;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    bF.enable = 1'b0; bF.req = '0; bF.grant_ack = 1'b0;
    b4.enable = 1'b0; b4.req = '0; b4.grant_ack = 1'b0;
    tick();
    tick();
    checkRr16("reset_rr16", 1'b0, 0);
    checkGrant("reset_fixed", bF.grant_valid, 64'(bF.grant_idx), 64'(bF.grant_onehot), 1'b0, 0);
    checkGrant("reset_rr4", b4.grant_valid, 64'(b4.grant_idx), 64'(b4.grant_onehot), 1'b0, 0);

    // Back-to-back alternation between requesters 0 and 7 with ack held high.
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0000, 1'b1);
    tick();
    checkRr16("noreq_idle", 1'b0, 0);
    applyStimulus(1'b1, 16'h0081, 1'b1);
    tick(); checkRr16("alt_0a", 1'b1, 0);
    tick(); checkRr16("alt_7a", 1'b1, 7);
    tick(); checkRr16("alt_0b", 1'b1, 0);
    tick(); checkRr16("alt_7b", 1'b1, 7);

    // Reset overrides a held grant and a concurrent ack.
    rst = 1'b1;
    tick();
    checkRr16("rst_over_ack", 1'b0, 0);

    // Full sweep with every request set, wrapping 15 -> 0.
    rst = 1'b0;
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 17; i++) begin
      tick();
      checkRr16($sformatf("sweep%0d", i), 1'b1, i % 16);
    end

    // Grant 5 must stay put through request withdrawal and enable low, then drop on ack.
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0020, 1'b0);
    tick();
    checkRr16("hold5_start", 1'b1, 5);
    applyStimulus(1'b0, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkRr16($sformatf("hold5_stable%0d", i), 1'b1, 5);
    end
    applyStimulus(1'b0, 16'h0001, 1'b1);
    tick();
    checkRr16("ack_en0_idle", 1'b0, 0);
    tick();
    checkRr16("idle_ack_ignored", 1'b0, 0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    tick();
    checkRr16("ptr_after_5", 1'b1, 6);

    // Reset during a hold of index 9 discards it and the pointer restarts at 0.
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0200, 1'b0);
    tick();
    checkRr16("hold9", 1'b1, 9);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h0200, 1'b1);
    tick();
    checkRr16("rst_mid_hold", 1'b0, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    tick();
    checkRr16("after_rst_grant0", 1'b1, 0);

    // Fixed priority keeps picking 2 over 15; the 4-way ring alternates 1 and 3.
    bF.enable = 1'b1; bF.req = 16'h8004; bF.grant_ack = 1'b1;
    b4.enable = 1'b1; b4.req = 4'b1010; b4.grant_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkGrant($sformatf("fixed_low%0d", i), bF.grant_valid, 64'(bF.grant_idx),
                 64'(bF.grant_onehot), 1'b1, 2);
      checkGrant($sformatf("rr4_%0d", i), b4.grant_valid, 64'(b4.grant_idx),
                 64'(b4.grant_onehot), 1'b1, (i % 2 == 0) ? 1 : 3);
    end
    bF.req = 16'h8000;
    tick();
    checkGrant("fixed_only15", bF.grant_valid, 64'(bF.grant_idx), 64'(bF.grant_onehot), 1'b1, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
